// File: rtl/fb_write_sched_pkg.sv
// Shared types and defaults for the framebuffer write scheduler.
// Holds the FSM state encoding, grant encoding and default geometry.
package fb_pkg;

  localparam int          ADDR_W_DEF      = 12;
  localparam int          DATA_W_DEF      = 8;
  localparam int          FB_WORDS_DEF    = 4096;
  localparam logic [7:0]  CLEAR_COLOR_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    START  = 2'd2,
    RENDER = 2'd3
  } state_e;

  typedef enum logic {
    GNT_R = 1'b0,
    GNT_C = 1'b1
  } grant_e;

endpackage

// File: rtl/fb_write_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester is always served; when both
// request, the side that was not granted last wins.
module rr_arb2
  import fb_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_valid_a,
  input  logic i_valid_b,
  output logic o_ready_a,
  output logic o_ready_b
);

  grant_e r_last_grant;

  // Each ready looks only at the opposite valid, so no side's ready depends on its own valid.
  assign o_ready_a = i_enable & (~i_valid_b | (r_last_grant == GNT_C));
  assign o_ready_b = i_enable & (~i_valid_a | (r_last_grant == GNT_R));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_last_grant <= GNT_C;
    end else if (i_valid_a && o_ready_a) begin
      r_last_grant <= GNT_R;
    end else if (i_valid_b && o_ready_b) begin
      r_last_grant <= GNT_C;
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// Frame scheduler for the framebuffer write port: clear, kick the renderer,
// then arbitrate renderer and CPU writes onto one registered RAM port.
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                FB_WORDS    = FB_WORDS_DEF,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = CLEAR_COLOR_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vsync,
  input  logic              i_clear_en,
  output logic              o_render_start,
  input  logic              i_render_done,
  input  logic              i_r_valid,
  output logic              o_r_ready,
  input  logic [ADDR_W-1:0] i_r_addr,
  input  logic [DATA_W-1:0] i_r_data,
  input  logic              i_c_valid,
  output logic              o_c_ready,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_ram_d,
  output logic              o_busy,
  output logic              o_frame_overrun
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_vsync_q;
  logic              w_vsync_edge;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_clr_last;
  logic              w_arb_r_ready;
  logic              w_arb_c_ready;
  logic              w_r_xfer;
  logic              w_c_xfer;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_ram_d;
  logic              r_render_start;
  logic              r_frame_overrun;

  assign w_vsync_edge = i_vsync & ~r_vsync_q;
  assign w_clr_last   = (r_clr_cnt == ADDR_W'(FB_WORDS - 1));

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (r_state == RENDER),
    .i_valid_a (i_r_valid),
    .i_valid_b (i_c_valid),
    .o_ready_a (w_arb_r_ready),
    .o_ready_b (w_arb_c_ready)
  );

  // Readies are gated by reset directly so nothing is accepted while it is held low.
  assign o_r_ready = i_reset & w_arb_r_ready;
  assign o_c_ready = i_reset & ((r_state == IDLE) | w_arb_c_ready);
  assign w_r_xfer  = i_r_valid & o_r_ready;
  assign w_c_xfer  = i_c_valid & o_c_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_vsync_edge) w_state_nxt = i_clear_en ? CLEAR : START;
      CLEAR:   if (w_clr_last)   w_state_nxt = START;
      START:   w_state_nxt = RENDER;
      RENDER:  if (i_render_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state         <= IDLE;
      r_vsync_q       <= 1'b0;
      r_clr_cnt       <= '0;
      r_render_start  <= 1'b0;
      r_frame_overrun <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_vsync_q       <= i_vsync;
      r_render_start  <= (w_state_nxt == START);
      r_frame_overrun <= w_vsync_edge & (r_state != IDLE);
      if (r_state == CLEAR) begin
        r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + ADDR_W'(1);
      end
    end
  end

  // At most one of w_r_xfer / w_c_xfer is set; the arbiter never grants both.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_ram_d <= '0;
    end else if (r_state == CLEAR) begin
      r_we    <= 1'b1;
      r_addr  <= r_clr_cnt;
      r_ram_d <= CLEAR_COLOR;
    end else if (w_r_xfer) begin
      r_we    <= 1'b1;
      r_addr  <= i_r_addr;
      r_ram_d <= i_r_data;
    end else if (w_c_xfer) begin
      r_we    <= 1'b1;
      r_addr  <= i_c_addr;
      r_ram_d <= i_c_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign o_we            = r_we;
  assign o_addr          = r_addr;
  assign o_ram_d         = r_ram_d;
  assign o_render_start  = r_render_start;
  assign o_frame_overrun = r_frame_overrun;
  assign o_busy          = (r_state != IDLE);

endmodule
